// File: rtl/texture_r8_block_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : texture_r8_block_encoder_pkg
// Description : Shared render constants for the R8 texture format and the
//               RGBA5652 texel layout, plus the RGBA5652 -> R8 quantizer.
// Revision    : 1.0 - initial release
// ============================================================================
package texture_r8_block_encoder_pkg;

  // Texture format code of the single-channel 8-bit layout
  localparam logic [3:0] TEX_FMT_R8 = 4'd6;

  // RGBA5652 field positions (shared with the texel decoder)
  localparam int RGBA_R_MSB = 17;
  localparam int RGBA_R_LSB = 13;
  localparam int RGBA_G_MSB = 12;
  localparam int RGBA_G_LSB = 7;
  localparam int RGBA_B_MSB = 6;
  localparam int RGBA_B_LSB = 2;
  localparam int RGBA_A_MSB = 1;
  localparam int RGBA_A_LSB = 0;

  // Block geometry: 4x4 texels, one byte each
  localparam int BLK_TEXELS = 16;
  localparam int BLK_BITS   = 128;

  // Green carries the luminance; its top two bits are replicated into the
  // low bits so that the decoder's R8[7:2] gives back the original G6.
  function automatic logic [7:0] rgba5652_to_r8(input logic [17:0] px);
    logic [5:0] g;
    g = px[RGBA_G_MSB:RGBA_G_LSB];
    return {g, g[5:4]};
  endfunction

endpackage : texture_r8_block_encoder_pkg
`default_nettype wire

// File: rtl/texture_r8_block_encoder.sv
`default_nettype none
// ============================================================================
// Module      : texture_r8_block_encoder
// Description : Streams RGBA5652 texels (row-major, one per cycle) into
//               128-bit R8 4x4 blocks. An assembly register fills the next
//               block while the output register waits for the writer.
// Revision    : 1.0 - initial release
// ============================================================================
module texture_r8_block_encoder
  import texture_r8_block_encoder_pkg::*;
#(
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [17:0]   in_rgba5652,
  input  logic          in_flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block_data,
  output logic [4:0]    out_texel_count,
  output logic          busy
);

  // Assembly side
  logic [3:0]   r_wr_idx;
  logic [127:0] r_asm;
  logic [4:0]   r_asm_count;
  logic         r_asm_full;

  // Output side
  logic [127:0] r_out_data;
  logic [4:0]   r_out_count;
  logic         r_out_valid;

  logic         w_in_hs;
  logic         w_out_hs;
  logic         w_complete;
  logic         w_out_free;
  logic         w_load_new;
  logic         w_load_asm;
  logic [7:0]   w_byte;
  logic [4:0]   w_count;
  logic [127:0] w_blk;

  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_byte     = rgba5652_to_r8(in_rgba5652);
  assign w_count    = {1'b0, r_wr_idx} + 5'd1;
  assign w_complete = w_in_hs && ((r_wr_idx == 4'd15) || in_flush);
  // Output register can take a block if empty or emptying this cycle
  assign w_out_free = !r_out_valid || out_ready;
  assign w_load_new = w_complete && w_out_free;
  // asm_full blocks input, so this never coincides with w_load_new
  assign w_load_asm = r_asm_full && w_out_hs;

  // Completed block view: stored bytes below the index, incoming byte at it, pad above
  always_comb begin
    w_blk = '0;
    for (int t = 0; t < BLK_TEXELS; t++) begin
      if (5'(t) < {1'b0, r_wr_idx}) begin
        w_blk[8*t +: 8] = r_asm[8*t +: 8];
      end else if (5'(t) == {1'b0, r_wr_idx}) begin
        w_blk[8*t +: 8] = w_byte;
      end else begin
        w_blk[8*t +: 8] = PAD_VALUE;
      end
    end
  end

  // Assembly register: collect texels, park a finished block when the output is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx    <= 4'd0;
      r_asm       <= '0;
      r_asm_count <= 5'd0;
      r_asm_full  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_wr_idx <= 4'd0;
        if (!w_out_free) begin
          r_asm       <= w_blk;
          r_asm_count <= w_count;
          r_asm_full  <= 1'b1;
        end
      end else if (w_in_hs) begin
        r_asm[{r_wr_idx, 3'b000} +: 8] <= w_byte;
        r_wr_idx                       <= r_wr_idx + 4'd1;
      end else if (w_load_asm) begin
        r_asm_full <= 1'b0;
      end
    end
  end

  // Output register: load a fresh or parked block, drop valid after a plain handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_count <= 5'd0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load_new) begin
        r_out_data  <= w_blk;
        r_out_count <= w_count;
        r_out_valid <= 1'b1;
      end else if (w_load_asm) begin
        r_out_data  <= r_asm;
        r_out_count <= r_asm_count;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready        = !r_asm_full;
  assign out_valid       = r_out_valid;
  assign out_block_data  = r_out_data;
  assign out_texel_count = r_out_count;
  assign busy            = (r_wr_idx != 4'd0) || r_asm_full || r_out_valid;

endmodule : texture_r8_block_encoder
`default_nettype wire

// File: tb/tb_texture_r8_block_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_texture_r8_block_encoder
// Description : Self-checking bench: transaction-level scoreboard of blocks
//               held by the encoder, directed scenarios and a random
//               grayscale round trip through the R8 decode rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_texture_r8_block_encoder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [17:0]  in_rgba5652 = '0;
  logic         in_flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block_data;
  logic [4:0]   out_texel_count;
  logic         busy;

  texture_r8_block_encoder #(.PAD_VALUE(8'h00)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rgba5652     (in_rgba5652),
    .in_flush        (in_flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_block_data  (out_block_data),
    .out_texel_count (out_texel_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0] d;
    logic [4:0]   c;
  } blk_t;

  logic [7:0] m_part[$];   // bytes of the block being assembled
  blk_t       m_q[$];      // completed blocks not yet taken downstream
  logic [5:0] rt_q[$];     // G6 values expected back by the round trip

  int           n_blocks = 0;
  int           vcycles = 0;
  int           rt_blocks = 0;
  bit           rt_en = 1'b0;
  logic [127:0] last_blk = '0;
  logic [4:0]   last_cnt = '0;

  function automatic logic [7:0] quant(input logic [17:0] px);
    logic [5:0] g;
    g = px[12:7];
    return {g, g[5:4]};
  endfunction

  function automatic logic [17:0] gray(input logic [5:0] g);
    return {g[5:1], g, g[5:1], 2'b11};
  endfunction

  // Compare at the falling edge, then apply the handshakes the next rising edge will see
  always @(negedge clk) begin
    if (!rst_n) begin
      m_part.delete();
      m_q.delete();
      rt_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_data", out_block_data, 0);
      check("rst_count", out_texel_count, 0);
    end else begin
      check("in_ready", in_ready, m_q.size() < 2);
      check("out_valid", out_valid, m_q.size() > 0);
      check("busy", busy, (m_q.size() > 0) || (m_part.size() > 0));
      if (out_valid) vcycles++;
      if (out_valid && m_q.size() > 0) begin
        check("out_data", out_block_data, m_q[0].d);
        check("out_count", out_texel_count, m_q[0].c);
      end
      if (out_valid && out_ready) begin
        n_blocks++;
        last_blk = out_block_data;
        last_cnt = out_texel_count;
        if (rt_en && out_texel_count == 5'd16) begin
          bit ok;
          logic [7:0] b;
          logic [5:0] want;
          ok = 1'b1;
          for (int t = 0; t < 16; t++) begin
            b = out_block_data[8*t +: 8];
            want = (rt_q.size() > 0) ? rt_q.pop_front() : 6'bx;
            if (b[7:2] !== want) ok = 1'b0;
          end
          check("round_trip", ok, 1);
          rt_blocks++;
        end
        if (m_q.size() > 0) void'(m_q.pop_front());
      end
      if (in_valid && in_ready) begin
        m_part.push_back(quant(in_rgba5652));
        if (rt_en) rt_q.push_back(in_rgba5652[12:7]);
        if (m_part.size() == 16 || in_flush) begin
          blk_t nb;
          nb.d = '0;
          for (int t = 0; t < m_part.size(); t++) nb.d[8*t +: 8] = m_part[t];
          nb.c = 5'(m_part.size());
          m_q.push_back(nb);
          m_part.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] px, input bit fl);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b1;
    in_rgba5652 = px;
    in_flush = fl;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  bit hold = 1'b0;
  task automatic rand_cycle(input bit allow_flush);
    bit a;
    if (!hold) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_rgba5652 = gray(6'($urandom));
      in_flush = allow_flush && ($urandom_range(0, 5) == 0);
    end
    out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    a = in_ready;
    hold = in_valid && !a;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int nb0;
    int acc;
    int cyc;
    bit a;
    logic [17:0] px;

    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Full block, G6 = 4*i, no backpressure
    out_ready = 1'b1;
    vcycles = 0;
    nb0 = n_blocks;
    for (int i = 0; i < 16; i++) send(gray(6'(4 * i)), 1'b0);
    @(negedge clk);
    check("full_valid_next_cycle", out_valid, 1);
    tick(4);
    check("full_valid_cycles", vcycles, 1);
    check("full_nblocks", n_blocks, nb0 + 1);
    check("full_byte1", last_blk[15:8], 8'h10);
    check("full_byte15", last_blk[127:120], 8'hF3);
    check("full_count", last_cnt, 16);

    // Backpressure: 33 texels offered with out_ready low
    out_ready = 1'b0;
    acc = 0;
    px = gray(6'($urandom));
    in_valid = 1'b1;
    in_rgba5652 = px;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        in_rgba5652 = gray(6'($urandom));
      end
    end
    check("bp_accepted", acc, 32);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_back", in_ready, 1);
    check("bp_block1_valid", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(4);
    send(gray(6'h00), 1'b1);
    tick(3);
    check("bp_tail_count", last_cnt, 2);

    // Partial flush of 5 saturated texels
    nb0 = n_blocks;
    for (int i = 0; i < 5; i++) send(gray(6'h3F), i == 4);
    tick(3);
    check("flush_nblocks", n_blocks, nb0 + 1);
    check("flush_data", last_blk, 128'h0000_0000_0000_0000_0000_00FF_FFFF_FFFF);
    check("flush_count", last_cnt, 5);
    for (int i = 0; i < 16; i++) send(gray(6'(i)), 1'b0);
    tick(3);
    check("after_flush_count", last_cnt, 16);
    check("after_flush_byte1", last_blk[15:8], 8'h04);

    // Channel isolation: only green contributes
    nb0 = n_blocks;
    for (int i = 0; i < 16; i++) send({5'h1F, 6'h00, 5'h1F, 2'b00}, 1'b0);
    tick(3);
    check("iso_nblocks", n_blocks, nb0 + 1);
    check("iso_data", last_blk, 128'h0);

    // Reset mid-block with a block pending at the output
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(gray(6'h2A), 1'b0);
    for (int i = 0; i < 7; i++) send(gray(6'h15), 1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    nb0 = n_blocks;
    for (int i = 0; i < 16; i++) send(gray(6'(i * 3 + 1)), 1'b0);
    tick(4);
    check("post_rst_nblocks", n_blocks, nb0 + 1);
    check("post_rst_count", last_cnt, 16);
    check("post_rst_byte0", last_blk[7:0], 8'h04);

    // Random traffic with flushes and backpressure
    hold = 1'b0;
    for (int c = 0; c < 400; c++) rand_cycle(1'b1);
    in_valid = 1'b0;
    in_flush = 1'b0;
    hold = 1'b0;
    out_ready = 1'b1;
    tick(4);
    send(gray(6'h00), 1'b1);
    tick(4);
    check("rand_idle", busy, 0);

    // Round trip: 1000 grayscale blocks through encode + R8 decode
    rt_en = 1'b1;
    cyc = 0;
    while (rt_blocks < 1000 && cyc < 60000) begin
      rand_cycle(1'b0);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("round_trip_blocks", rt_blocks >= 1000, 1);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_texture_r8_block_encoder
`default_nettype wire
